// File: rtl/ixc_capture_pkg.sv
// ixc_capture_pkg: shared types and sizing for the ixc_capture change-log block.
package ixc_capture_pkg;
  localparam int CAP_W = 4;
  localparam int CAP_TS_W = 16;
  localparam int CAP_DEPTH = 4;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  localparam int LVL_W = lvl_w(CAP_DEPTH);
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  typedef struct packed {
    logic [CAP_W-1:0]    data;
    logic [CAP_TS_W-1:0] ts;
    logic                init;
  } rec_t;
endpackage

// File: rtl/ixc_capture_if.sv
// ixc_capture_if: valid/ready event-record channel from capture logic to its consumer.
interface ixc_capture_if
  import ixc_capture_pkg::*;
#(
  parameter int WIDTH = CAP_W,
  parameter int TS_W  = CAP_TS_W
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TS_W-1:0]  out_ts;
  logic             out_init;
  modport master (output out_valid, out_data, out_ts, out_init, input out_ready);
  modport slave  (input out_valid, out_data, out_ts, out_init, output out_ready);
endinterface

// File: rtl/ixc_capture_fifo.sv
// ixc_capture_fifo: register-array FIFO; a push while full is accepted only alongside a pop.
module ixc_capture_fifo
  import ixc_capture_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [W-1:0]            din_i,
  output logic [W-1:0]            dout_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [lvl_w(DEPTH)-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;
  assign empty_o = level_q == '0;
  assign full_o  = level_q == (AW+1)'(DEPTH);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_q];
  assign level_o = level_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (do_push) mem_q[wr_q] <= din_i;
      wr_q    <= wr_q + AW'(do_push);
      rd_q    <= rd_q + AW'(do_pop);
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/ixc_capture_4.sv
// ixc_capture_4: logs value changes of a 4-bit assigned net into an event FIFO.
// Define IXC_CAPTURE_TSTAMP_EN to attach a cycle timestamp to each record on out_ts.
module ixc_capture_4
  import ixc_capture_pkg::*;
#(
  parameter int WIDTH  = CAP_W,
  parameter int TS_W   = CAP_TS_W,
  parameter int DEPTH  = CAP_DEPTH,
  parameter int LOST_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [WIDTH-1:0]        val,
  ixc_capture_if.master           cap,
  input  logic                    ovf_clr,
  output logic                    overflow,
  output logic [LOST_W-1:0]       lost,
  output logic [lvl_w(DEPTH)-1:0] level
);
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic              overflow_q, overflow_d;
  logic [LOST_W-1:0] lost_q, lost_d;
  logic              push, pop, drop, full, empty, is_init;
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    push    = 1'b0;
    case (state_q)
      IDLE:  state_d = en ? PRIME : IDLE;
      PRIME: begin
        state_d = en ? RUN : IDLE;
        push    = en;
        prev_d  = en ? val : prev_q;
      end
      RUN: begin
        state_d = en ? RUN : IDLE;
        push    = en && (val != prev_q);
        prev_d  = push ? val : prev_q;
      end
      default: state_d = IDLE;
    endcase
  end
  assign is_init       = state_q == PRIME;
  assign cap.out_valid = !empty;
  assign pop           = !empty && cap.out_ready;
  assign drop          = push && full && !pop;
  // A drop in the same cycle as a clear wins, so the new loss is never hidden.
  assign overflow_d = drop || (overflow_q && !ovf_clr);
  assign lost_d = drop ? (ovf_clr ? LOST_W'(1) : (&lost_q ? lost_q : lost_q + 1'b1))
                : ovf_clr ? '0 : lost_q;
  assign overflow = overflow_q;
  assign lost     = lost_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      overflow_q <= 1'b0;
      lost_q     <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
      lost_q     <= lost_d;
    end
  end
`ifdef IXC_CAPTURE_TSTAMP_EN
  localparam int RW = $bits(rec_t);
  logic [TS_W-1:0] ts_q;
  rec_t            rin, rout;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= state_q != IDLE ? ts_q + 1'b1 : ts_q;
  end
  assign rin          = '{data: val, ts: ts_q, init: is_init};
  assign cap.out_data = rout.data;
  assign cap.out_ts   = rout.ts;
  assign cap.out_init = rout.init;
`else
  localparam int RW = WIDTH + 1;
  logic [RW-1:0] rin, rout;
  assign rin = {val, is_init};
  assign {cap.out_data, cap.out_init} = rout;
  assign cap.out_ts = '0;
`endif
  ixc_capture_fifo #(.W(RW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (rin),
    .dout_o  (rout),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );
endmodule
